multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle CPU control decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, so the ALU and memory can be shared across cycles. It adds a memory wait-state handshake, a HALT state and a retired-instruction counter. It sits between the instruction register and the shared datapath of the 16-bit CPU.

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 118 +++++++++++
 tb/tb_multicycle_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control-unit bus between the IR/datapath (slave) and the sequencer (master)
interface multicycle_control_if #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic zero;
  logic mem_ready;
  logic pc_write;
  logic [1:0] pc_src;
  logic ir_write;
  logic iord;
  logic mem_read;
  logic mem_write;
  logic alu_src;
  logic reg_write;
  logic reg_dst;
  logic mem_to_reg;
  logic branch;
  logic jump;
  logic [2:0] state;
  logic instr_done;
  logic halted;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src,
    output reg_write, reg_dst, mem_to_reg, branch, jump, state, instr_done, halted, instr_count
  );
  modport slave (
    output opcode, zero, mem_ready,
    input pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src,
    input reg_write, reg_dst, mem_to_reg, branch, jump, state, instr_done, halted, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with mem wait states, HALT and retire counter.
// Optional ILLEGAL_TRAP_EN sends opcodes >= 8 to TRAP instead of running them as NOP.
module multicycle_control #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_e;
  state_e state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_q;
  logic dec_illegal, op_illegal, dec_halt, done;
  logic is_r, is_lw, is_sw, is_beq, is_addi, is_j;
  // Only codes with a bit set above bit 2 are illegal; a 3-bit opcode has none.
  if (OPCODE_W > 3) begin : g_wide
    assign dec_illegal = |bus.opcode[OPCODE_W-1:3];
    assign op_illegal = |op_q[OPCODE_W-1:3];
  end else begin : g_narrow
    assign dec_illegal = 1'b0;
    assign op_illegal = 1'b0;
  end
  assign dec_halt = !dec_illegal && bus.opcode[2:0] == 3'd7;
  assign is_r = !op_illegal && op_q[2:0] == 3'd0;
  assign is_lw = !op_illegal && op_q[2:0] == 3'd1;
  assign is_sw = !op_illegal && op_q[2:0] == 3'd2;
  assign is_beq = !op_illegal && op_q[2:0] == 3'd3;
  assign is_addi = !op_illegal && op_q[2:0] == 3'd4;
  assign is_j = !op_illegal && op_q[2:0] == 3'd5;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    done = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src = 2'd0;
    bus.ir_write = 1'b0;
    bus.iord = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_src = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_dst = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.branch = 1'b0;
    bus.jump = 1'b0;
    bus.halted = 1'b0;
    // Everything stays quiet while reset is asserted, whatever the state.
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
          state_d = bus.mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          op_d = bus.opcode;
          done = dec_halt;
`ifdef ILLEGAL_TRAP_EN
          state_d = dec_halt ? HALT : dec_illegal ? TRAP : EXEC;
`else
          state_d = dec_halt ? HALT : EXEC;
`endif
        end
        EXEC: begin
          bus.alu_src = is_lw || is_sw || is_addi;
          bus.branch = is_beq;
          bus.jump = is_j;
          bus.pc_src = is_beq ? 2'd1 : is_j ? 2'd2 : 2'd0;
          bus.pc_write = (is_beq && bus.zero) || is_j;
          done = !(is_r || is_lw || is_sw || is_addi);
          state_d = (is_lw || is_sw) ? MEM : (is_r || is_addi) ? WB : FETCH;
        end
        MEM: begin
          bus.iord = 1'b1;
          bus.alu_src = 1'b1;
          bus.mem_read = is_lw;
          bus.mem_write = !is_lw;
          done = !is_lw && bus.mem_ready;
          state_d = !bus.mem_ready ? MEM : is_lw ? WB : FETCH;
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst = is_r;
          bus.mem_to_reg = is_lw;
          done = 1'b1;
          state_d = FETCH;
        end
        HALT, TRAP: bus.halted = 1'b1;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_q + CNT_W'(done);
    end
  end
  assign bus.state = state_q;
  assign bus.instr_done = done;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle sequencer (default and narrow-counter/wide-opcode builds)
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int checks = 0;
  int errors = 0;
  int pcw_exec, irw, regw, regw_mtr, memw, mr_bad, last_reg_dst;
  multicycle_control_if #(.OPCODE_W(3), .CNT_W(16)) a ();
  multicycle_control_if #(.OPCODE_W(4), .CNT_W(4)) b ();
  multicycle_control #(.OPCODE_W(3), .CNT_W(16)) dut_a (.clk(clk), .reset(rst_a), .bus(a));
  multicycle_control #(.OPCODE_W(4), .CNT_W(4)) dut_b (.clk(clk), .reset(rst_b), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [3:0] op, input logic [3:0] late, input logic z, input int fw, input int mw, output int cyc);
    int f = 0;
    int m = 0;
    bit fin = 1'b0;
    cyc = 0;
    pcw_exec = 0; irw = 0; regw = 0; regw_mtr = 0; memw = 0; mr_bad = 0; last_reg_dst = 0;
    while (!fin && cyc < 40) begin
      a.opcode = (a.state == 3'd0 || a.state == 3'd1) ? op[2:0] : late[2:0];
      a.zero = z;
      a.mem_ready = (a.state == 3'd0) ? (f >= fw) : (a.state == 3'd3) ? (m >= mw) : 1'b1;
      #1;
      cyc++;
      if (a.state == 3'd0) f++;
      if (a.state == 3'd3) m++;
      if (a.state == 3'd2 && a.pc_write) pcw_exec++;
      if ((a.state == 3'd0 || (a.state == 3'd3 && op == 4'd1)) && !a.mem_read) mr_bad++;
      if (a.reg_write) begin
        regw++;
        last_reg_dst = a.reg_dst;
        if (a.mem_to_reg && a.state == 3'd4) regw_mtr++;
      end
      irw += a.ir_write;
      memw += a.mem_write;
      fin = a.instr_done;
      tick();
    end
    check("instr_finished", fin, 1);
  endtask
  initial begin
    logic [3:0] prog_op [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd5, 4'd6};
    logic prog_z [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int prog_cyc [7] = '{4, 5, 4, 3, 3, 3, 3};
    int prog_pcw [7] = '{0, 0, 0, 1, 0, 1, 0};
    int cyc;
    int strobes;
    int halt_lost;
    a.opcode = 3'd0; a.zero = 1'b0; a.mem_ready = 1'b1;
    b.opcode = 4'd0; b.zero = 1'b0; b.mem_ready = 1'b1;
    tick();
    tick();
    check("rst_mem_read", a.mem_read, 0);
    check("rst_ir_write", a.ir_write, 0);
    check("rst_state", a.state, 0);
    check("rst_count", a.instr_count, 0);
    rst_a = 1'b0;
    #1;
    check("fetch_mem_read", a.mem_read, 1);
    for (int i = 0; i < 7; i++) begin
      run(prog_op[i], prog_op[i], prog_z[i], 0, 0, cyc);
      check($sformatf("prog%0d_cycles", i), cyc, prog_cyc[i]);
      check($sformatf("prog%0d_exec_pc_write", i), pcw_exec, prog_pcw[i]);
    end
    check("prog_count", a.instr_count, 7);
    run(4'd1, 4'd1, 1'b0, 2, 3, cyc);
    check("lw_wait_cycles", cyc, 10);
    check("lw_wait_ir_write", irw, 1);
    check("lw_wait_reg_write", regw, 1);
    check("lw_wait_mem_to_reg_wb", regw_mtr, 1);
    check("lw_wait_mem_read_drop", mr_bad, 0);
    check("lw_wait_count", a.instr_count, 8);
    run(4'd0, 4'd2, 1'b0, 0, 0, cyc);
    check("late_op_cycles", cyc, 4);
    check("late_op_reg_write", regw, 1);
    check("late_op_reg_dst", last_reg_dst, 1);
    check("late_op_mem_write", memw, 0);
    run(4'd7, 4'd7, 1'b0, 0, 0, cyc);
    check("halt_cycles", cyc, 2);
    check("halt_halted", a.halted, 1);
    check("halt_state", a.state, 5);
    check("halt_count", a.instr_count, 10);
    strobes = 0;
    halt_lost = 0;
    for (int i = 0; i < 20; i++) begin
      a.opcode = 3'($urandom_range(0, 7));
      a.mem_ready = 1'($urandom_range(0, 1));
      a.zero = 1'($urandom_range(0, 1));
      #1;
      strobes += int'(a.pc_write) + int'(a.ir_write) + int'(a.mem_read) + int'(a.mem_write)
               + int'(a.reg_write) + int'(a.instr_done) + int'(a.branch) + int'(a.jump);
      if (!a.halted || a.state != 3'd5) halt_lost++;
      tick();
    end
    check("halt_strobes", strobes, 0);
    check("halt_held", halt_lost, 0);
    check("halt_count_held", a.instr_count, 10);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("halt_reset_state", a.state, 0);
    check("halt_reset_count", a.instr_count, 0);
    a.opcode = 3'd2;
    a.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    a.mem_ready = 1'b0;
    #1;
    check("sw_mem_state", a.state, 3);
    check("sw_mem_write", a.mem_write, 1);
    tick();
    rst_a = 1'b1;
    #1;
    check("sw_rst_mem_write", a.mem_write, 0);
    check("sw_rst_reg_write", a.reg_write, 0);
    tick();
    rst_a = 1'b0;
    #1;
    check("sw_rst_state", a.state, 0);
    check("sw_rst_count", a.instr_count, 0);
    rst_b = 1'b0;
    b.opcode = 4'd6;
    for (int i = 0; i < 45; i++) tick();
    check("nop15_count", b.instr_count, 15);
    tick();
    tick();
    #1;
    check("nop16_done", b.instr_done, 1);
    tick();
    check("nop16_wrap", b.instr_count, 0);
    b.opcode = 4'd9;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    check("trap_state", b.state, 6);
    check("trap_halted", b.halted, 1);
    tick();
    tick();
    check("trap_state_held", b.state, 6);
    check("trap_count", b.instr_count, 0);
`else
    check("illegal_exec_state", b.state, 2);
    check("illegal_done", b.instr_done, 1);
    check("illegal_halted", b.halted, 0);
    tick();
    check("illegal_fetch", b.state, 0);
    check("illegal_count", b.instr_count, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
